// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
// Module : manchester_pkg
// Brief  : Receiver state encoding, error bit positions and default sync word
// Rev    : 1.0  initial release
// ============================================================================
package manchester_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_HUNT    = 2'd2;
    localparam logic [1:0] c_ST_DATA    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_MEASURE = c_ST_MEASURE,
        ST_HUNT    = c_ST_HUNT,
        ST_DATA    = c_ST_DATA
    } state_e;

    localparam int c_ERR_BAD_PERIOD = 0;
    localparam int c_ERR_NO_SYNC    = 1;
    localparam int c_ERR_OVERFLOW   = 2;

    localparam logic [7:0] c_SYNC_WORD_DEFAULT = 8'hD5;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : sync_edge_detect
// Brief  : Two-flop synchroniser for the line input plus rising/falling edge
//          compare; an edge is visible to the consumer 3 clocks after the pin
// Rev    : 1.0  initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pos_edge,
    output logic neg_edge
);

    logic r_meta_q, r_sync_q, r_prev_q;
    logic w_meta_d, w_sync_d, w_prev_d;

    always_comb begin
        w_meta_d = din;
        w_sync_d = r_meta_q;
        w_prev_d = r_sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
        end
    end

    assign pos_edge =  r_sync_q & ~r_prev_q;
    assign neg_edge = ~r_sync_q &  r_prev_q;

endmodule
`default_nettype wire

// File: rtl/manchester_frame_rx.sv
`default_nettype none
// ============================================================================
// Module : manchester_frame_rx
// Brief  : Self-clocking Manchester frame receiver: measures the bit period,
//          hunts for the sync word and stores payload bytes in a small buffer
// Rev    : 1.0  initial release
// ============================================================================
module manchester_frame_rx
    import manchester_pkg::*;
#(
    parameter int         CNT_W      = 12,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] SYNC_WORD  = c_SYNC_WORD_DEFAULT,
    parameter int         MIN_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     digital_in,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   byte_count,
    output logic                     frame_valid,
    output logic                     busy,
    output logic [CNT_W-1:0]         bit_period,
    output logic [2:0]               err
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     c_FULL  = (AW+1)'(DEPTH);
    localparam logic [CNT_W:0]  c_MIN_P = (CNT_W+1)'(MIN_PERIOD);

    logic w_pos_edge, w_neg_edge;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (digital_in),
        .pos_edge (w_pos_edge),
        .neg_edge (w_neg_edge)
    );

    state_e           r_state_q,    w_state_d;
    logic [CNT_W-1:0] r_cnt_q,      w_cnt_d;
    logic [CNT_W-1:0] r_period_q,   w_period_d;
    logic [7:0]       r_shift_q,    w_shift_d;
    logic [2:0]       r_bit_cnt_q,  w_bit_cnt_d;
    logic [AW:0]      r_byte_cnt_q, w_byte_cnt_d;
    logic             r_valid_q,    w_valid_d;
    logic [2:0]       r_err_q,      w_err_d;
    logic [7:0]       r_rd_data_q,  w_rd_data_d;
    logic [7:0]       r_mem_q [DEPTH];

    logic             w_edge, w_cnt_sat, w_accept, w_eof, w_wr_en;
    logic [CNT_W:0]   w_elapsed, w_quarter, w_win_lo, w_win_hi;
    logic [CNT_W-1:0] w_cnt_run;
    logic [7:0]       w_shift_in;

    // Window math is one bit wider than the counter so P + P/4 cannot wrap.
    always_comb begin
        w_edge     = w_pos_edge | w_neg_edge;
        w_cnt_sat  = &r_cnt_q;
        w_elapsed  = {1'b0, r_cnt_q} + 1'b1;
        w_cnt_run  = w_cnt_sat ? r_cnt_q : w_elapsed[CNT_W-1:0];
        w_quarter  = {3'b000, r_period_q[CNT_W-1:2]};
        w_win_lo   = {1'b0, r_period_q} - w_quarter;
        w_win_hi   = {1'b0, r_period_q} + w_quarter;
        w_accept   = w_edge && (w_elapsed >= w_win_lo) && (w_elapsed <= w_win_hi);
        w_eof      = !w_accept && ((w_elapsed > w_win_hi) || w_cnt_sat);
        w_shift_in = {r_shift_q[6:0], w_pos_edge};
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_period_d   = r_period_q;
        w_shift_d    = r_shift_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_byte_cnt_d = r_byte_cnt_q;
        w_valid_d    = r_valid_q;
        w_err_d      = r_err_q;
        w_wr_en      = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_edge) begin
                    w_valid_d    = 1'b0;
                    w_byte_cnt_d = '0;
                    w_err_d      = '0;
                    w_cnt_d      = '0;
                    w_shift_d    = {7'b0, w_pos_edge};
                    w_state_d    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                w_cnt_d = w_cnt_run;
                if (w_cnt_sat) begin
                    w_err_d[c_ERR_BAD_PERIOD] = 1'b1;
                    w_state_d                 = ST_IDLE;
                end else if (w_edge) begin
                    w_period_d = w_elapsed[CNT_W-1:0];
                    w_shift_d  = w_shift_in;
                    w_cnt_d    = '0;
                    if (w_elapsed < c_MIN_P) begin
                        w_err_d[c_ERR_BAD_PERIOD] = 1'b1;
                        w_state_d                 = ST_IDLE;
                    end else begin
                        w_state_d = ST_HUNT;
                    end
                end
            end
            ST_HUNT: begin
                w_cnt_d = w_cnt_run;
                if (w_accept) begin
                    w_cnt_d   = '0;
                    w_shift_d = w_shift_in;
                    if (w_shift_in == SYNC_WORD) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = ST_DATA;
                    end
                end else if (w_eof) begin
                    w_err_d[c_ERR_NO_SYNC] = 1'b1;
                    w_state_d              = ST_IDLE;
                end
            end
            ST_DATA: begin
                w_cnt_d = w_cnt_run;
                if (w_accept) begin
                    w_cnt_d     = '0;
                    w_shift_d   = w_shift_in;
                    w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                    if (r_bit_cnt_q == 3'd7) begin
                        if (r_byte_cnt_q == c_FULL) begin
                            w_err_d[c_ERR_OVERFLOW] = 1'b1;
                        end else begin
                            w_wr_en      = 1'b1;
                            w_byte_cnt_d = r_byte_cnt_q + 1'b1;
                        end
                    end
                end else if (w_eof) begin
                    w_valid_d = (r_byte_cnt_q != '0);
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Addresses at or beyond the stored byte count read as zero, hiding stale RAM.
    always_comb begin
        w_rd_data_d = ({1'b0, rd_addr} < r_byte_cnt_q) ? r_mem_q[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_period_q   <= '0;
            r_shift_q    <= '0;
            r_bit_cnt_q  <= '0;
            r_byte_cnt_q <= '0;
            r_valid_q    <= 1'b0;
            r_err_q      <= '0;
            r_rd_data_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_period_q   <= w_period_d;
            r_shift_q    <= w_shift_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_byte_cnt_q <= w_byte_cnt_d;
            r_valid_q    <= w_valid_d;
            r_err_q      <= w_err_d;
            r_rd_data_q  <= w_rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem_q[r_byte_cnt_q[AW-1:0]] <= w_shift_in;
        end
    end

    assign rd_data     = r_rd_data_q;
    assign byte_count  = r_byte_cnt_q;
    assign frame_valid = r_valid_q;
    assign busy        = (r_state_q != ST_IDLE);
    assign bit_period  = r_period_q;
    assign err         = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_manchester_frame_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_manchester_frame_rx
// Brief  : Directed bench for manchester_frame_rx with a byte scoreboard
// Rev    : 1.0  initial release
// ============================================================================
module tb_manchester_frame_rx;

    localparam int CNT_W = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int H     = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             digital_in;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;
    logic [AW:0]      byte_count;
    logic             frame_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_period;
    logic [2:0]       err;

    always #5 clk = ~clk;

    manchester_frame_rx #(
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .SYNC_WORD  (8'hD5),
        .MIN_PERIOD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digital_in  (digital_in),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_count  (byte_count),
        .frame_valid (frame_valid),
        .busy        (busy),
        .bit_period  (bit_period),
        .err         (err)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cur_off  = 0;
    bit         jitter   = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One half-bit segment; mid-bit edges drift by at most one cycle per bit.
    task automatic half(input logic lvl, input bit mid);
        int o;
        o = cur_off;
        if (jitter && mid) begin
            o = cur_off + int'($urandom_range(2, 0)) - 1;
            if (o > 3)  o = 3;
            if (o < -3) o = -3;
        end
        repeat (H + o - cur_off) @(negedge clk);
        digital_in = lvl;
        cur_off    = o;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit payload);
        for (int i = 7; i >= 0; i--) begin
            half(~v[i], 1'b0);
            half(v[i], 1'b1);
        end
        if (payload && exp_q.size() < DEPTH) exp_q.push_back(v);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // A stray level change starts a measurement that saturates back to idle.
    task automatic line_to(input logic lvl);
        if (digital_in !== lvl) begin
            digital_in = lvl;
            repeat (4) @(negedge clk);
            wait_idle("line_settle", 5000);
        end
        cur_off = 0;
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [7:0] e);
        rd_addr = a;
        @(negedge clk);
        check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(e));
    endtask

    task automatic check_frame(input string tag, input logic [2:0] e_err,
                               input logic e_valid, input bit chk_p);
        int n;
        n = exp_q.size();
        check({tag, ".byte_count"}, 32'(byte_count), 32'(n));
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'(e_valid));
        check({tag, ".err"}, 32'(err), 32'(e_err));
        if (chk_p) check({tag, ".bit_period"}, 32'(bit_period), 32'd16);
        for (int i = 0; i < n; i++) read_chk(AW'(i), exp_q.pop_front());
        if (n < DEPTH) read_chk(AW'(n), 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_data"}, 32'(rd_data), 32'd0);
        check({tag, ".byte_count"}, 32'(byte_count), 32'd0);
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".bit_period"}, 32'(bit_period), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        digital_in = 1'b0;
        rd_addr    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal frame at P=16
        line_to(1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hA7, 1'b1);
        wait_idle("nominal.eof", 30);
        check_frame("nominal", 3'b000, 1'b1, 1'b1);

        // Same frame with wandering edge timing
        jitter  = 1'b1;
        cur_off = 0;
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hA7, 1'b1);
        wait_idle("jitter.eof", 30);
        check_frame("jitter", 3'b000, 1'b1, 1'b0);
        jitter = 1'b0;
        line_to(1'b1);

        // Overflow: 17 payload bytes into a 16-byte buffer
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int b = 0; b <= 16; b++) send_byte(8'(b), 1'b1);
        wait_idle("overflow.eof", 30);
        check_frame("overflow", 3'b100, 1'b1, 1'b1);

        // First two edges only two cycles apart
        line_to(1'b0);
        digital_in = 1'b1;
        repeat (2) @(negedge clk);
        digital_in = 1'b0;
        repeat (2) @(negedge clk);
        check("short.busy_measuring", 32'(busy), 32'd1);
        @(negedge clk);
        check("short.busy", 32'(busy), 32'd0);
        check("short.err", 32'(err), 32'b001);
        check("short.frame_valid", 32'(frame_valid), 32'd0);
        check("short.byte_count", 32'(byte_count), 32'd0);

        // 32 preamble bits, no sync word; idle within 21 cycles of the FSM seeing the edge
        line_to(1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'h55, 1'b0);
        wait_idle("nosync.busy_drop", 21 + 3);
        check_frame("nosync", 3'b010, 1'b0, 1'b1);

        // Reset pulse mid-frame, then a clean frame
        line_to(1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        line_to(1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h81, 1'b1);
        send_byte(8'h7E, 1'b1);
        wait_idle("after_reset.eof", 30);
        check_frame("after_reset", 3'b000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/manchester_frame_rx.md
MANCHESTER_FRAME_RX -- requirements
Module: manchester_frame_rx

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of the bit-period counter.
REQ-002 SHALL have parameter DEPTH, default 16: frame buffer depth in bytes, a power of two, minimum 2.
REQ-003 SHALL have parameter SYNC_WORD, default 8'hD5: start-of-frame delimiter.
REQ-004 SHALL have parameter MIN_PERIOD, default 4: smallest legal bit period in clk cycles.
REQ-005 SHALL have the port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have the port rst_n, input, width 1: reset, synchronous and active-low.
REQ-007 SHALL have the port digital_in, input, width 1: asynchronous Manchester line.
REQ-008 SHALL have the port rd_addr, input, width log2(DEPTH): buffer read address.
REQ-009 SHALL have the port rd_data, output, width 8: registered buffer read data.
REQ-010 SHALL have the port byte_count, output, width log2(DEPTH)+1: number of bytes stored in the current frame.
REQ-011 SHALL have the port frame_valid, output, width 1: a complete frame is held.
REQ-012 SHALL have the port busy, output, width 1: reception is in progress.
REQ-013 SHALL have the port bit_period, output, width CNT_W: measured period P.
REQ-014 SHALL have the port err, output, width 3: {overflow, no_sync, bad_period}, sticky per frame.

Function
REQ-015 digital_in SHALL pass through a 2-FF synchroniser followed by an edge compare; an edge event reaches the FSM 3 cycles after the pin changes.
REQ-016 Bit encoding SHALL follow IEEE 802.3: a rising mid-bit edge is 1, a falling edge is 0; bits are MSB first.
REQ-017 FSM states SHALL be IDLE, MEASURE, HUNT and DATA; busy SHALL be 1 in every state except IDLE.
REQ-018 In IDLE, any edge SHALL clear frame_valid, byte_count and err, clear the counter, shift the edge's bit in, and enter MEASURE.
REQ-019 In MEASURE, the counter SHALL increment each cycle; the next edge SHALL latch P equal to the cycles since the previous edge, shift its bit in, and enter HUNT.
REQ-020 In MEASURE, P < MIN_PERIOD or the counter saturating at all-ones SHALL set err[0] and return the FSM to IDLE.
REQ-021 In HUNT and DATA, the counter SHALL reset on every accepted edge.
REQ-022 In HUNT and DATA, edges SHALL be handled by counter value: edges with counter < P-(P>>2) are boundary edges and SHALL be ignored; an edge with counter in [P-(P>>2), P+(P>>2)] is accepted as the next bit.
REQ-023 The counter reaching P+(P>>2)+1 without an accepted edge SHALL be end-of-frame; the window arithmetic SHALL be CNT_W+1 bits wide so it cannot overflow.
REQ-024 In HUNT, an 8-bit shift register SHALL be compared after each accepted bit; a value equal to SYNC_WORD SHALL clear the bit counter and enter DATA.
REQ-025 End-of-frame in HUNT SHALL set err[1], leave frame_valid at 0, and enter IDLE.
REQ-026 In DATA, every 8th bit SHALL write the assembled byte to buffer[byte_count] and increment byte_count.
REQ-027 If byte_count == DEPTH when a byte completes, the byte SHALL be dropped, err[2] SHALL be set, byte_count SHALL hold, and reception SHALL continue to end-of-frame.
REQ-028 End-of-frame in DATA SHALL discard any partial byte, set frame_valid = (byte_count != 0), and enter IDLE.
REQ-029 frame_valid, byte_count, err and P SHALL hold until the next frame's first edge.
REQ-030 rd_data SHALL return buffer[rd_addr] one cycle after rd_addr is presented, and SHALL return 8'h00 when rd_addr >= byte_count.
REQ-031 A read of an address in the same cycle it is written SHALL return the old contents.

Reset
REQ-032 When rst_n is low at a clock edge, the state SHALL be IDLE and rd_data, byte_count, frame_valid, busy, bit_period, err, the synchroniser and the counter SHALL all be 0.
REQ-033 Buffer RAM SHALL NOT be reset; the masking in REQ-030 hides its stale contents.
REQ-034 Reset asserted mid-frame SHALL abort the frame; reception SHALL restart only on an edge seen after rst_n returns high.

Structure
REQ-035 Package manchester_pkg SHALL hold the FSM state enum, the err bit indices and the default SYNC_WORD.
REQ-036 The synchroniser and edge compare SHALL be one sub-module, sync_edge_detect (outputs pos_edge and neg_edge); the buffer SHALL be an inferred register array inside manchester_frame_rx.

Verification
REQ-037 P=16, preamble 0x55, then 0xD5, 0x3C, 0xA7, then idle -> bit_period=16, byte_count=2, frame_valid=1, err=0, rd_addr 0/1 give 0x3C/0xA7 after 1 cycle, rd_addr 2 gives 0x00.
REQ-038 Same frame with every edge shifted by a random offset of up to +/-3 cycles -> identical decoded bytes, err=0.
REQ-039 DEPTH=16, 17 payload bytes 0x00..0x10 -> byte_count=16, err[2]=1, frame_valid=1, rd_addr 15 gives 0x0F.
REQ-040 First two edges 2 cycles apart -> err[0]=1, busy=0 on the next cycle, frame_valid=0.
REQ-041 32 preamble bits then silence -> err[1]=1, frame_valid=0, byte_count=0, busy low within 21 cycles of the last edge.
REQ-042 rst_n low for 1 cycle after the 1st payload byte -> all outputs 0, and a following clean frame decodes correctly.
